// File: rtl/key_pkg.sv
// Shared definitions for the push-button debounce filter: per-channel state
// encoding and the default qualification time.
package key_pkg;

    localparam int DEBOUNCE_CYC_DEF = 1000000;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_FILT = 2'd1,
        ST_DOWN       = 2'd2,
        ST_REL_FILT   = 2'd3
    } key_fsm_e;

    // The debounced level is "pressed" once a press has qualified and until a release has.
    function automatic logic is_pressed(input key_fsm_e st);
        return (st == ST_DOWN) || (st == ST_REL_FILT);
    endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One push-button channel: 2-flop synchronizer, debounce FSM and qualification counter.
//
// state          | meaning
// ST_IDLE        | key released and stable
// ST_PRESS_FILT  | key seen low, waiting for a stable low of DEBOUNCE_CYC cycles
// ST_DOWN        | key pressed and stable
// ST_REL_FILT    | key seen high, waiting for a stable high of DEBOUNCE_CYC cycles
module key_filter_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_meta;
    logic             sync;
    key_fsm_e         state;
    key_fsm_e         state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // Synchronizer resets to 1 so an asserted reset looks like a released key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync      <= 1'b1;
        end else begin
            sync_meta <= key_n;
            sync      <= sync_meta;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!sync) begin
                    state_nxt = ST_PRESS_FILT;
                    cnt_nxt   = '0;
                end
            end
            ST_PRESS_FILT: begin
                if (sync) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_DOWN;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (sync) begin
                    state_nxt = ST_REL_FILT;
                    cnt_nxt   = '0;
                end
            end
            ST_REL_FILT: begin
                if (!sync) begin
                    state_nxt = ST_DOWN;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_IDLE;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            key_state     <= is_pressed(state_nxt);
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

endmodule

// File: rtl/key_filter.sv
// Multi-channel push-button debounce filter: one independent channel per key
// plus a combined "any key pressed" indication.
module key_filter
    import key_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic              key_any
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_filter_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .key_n         (key_n[i]),
            .key_state     (key_state[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

    assign key_any = |key_state;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed debounce scenarios plus randomized bouncing,
// checked every cycle against a run-length reference model.
module tb_key_filter;

    localparam int NK = 4;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_state;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic          key_any;

    int checks = 0;
    int errors = 0;

    key_filter #(.N_KEYS(NK), .DEBOUNCE_CYC(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_n         (key_n),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .key_any       (key_any)
    );

    always #5 clk = ~clk;

    // Reference: a key's debounced level flips once the synchronized input has
    // disagreed with it for D+1 consecutive samples; the input reaches the
    // decision two edges after it is sampled.
    logic [NK-1:0] pipe0, pipe1;
    logic [NK-1:0] m_state, m_press, m_rel;
    int            run [NK];

    task automatic model_reset();
        pipe0 = '1; pipe1 = '1;
        m_state = '0; m_press = '0; m_rel = '0;
        for (int i = 0; i < NK; i++) run[i] = 0;
    endtask

    task automatic model_edge(input logic [NK-1:0] kn);
        for (int i = 0; i < NK; i++) begin
            logic pressed_now;
            pressed_now = ~pipe1[i];
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            if (pressed_now != m_state[i]) begin
                run[i] = run[i] + 1;
                if (run[i] == D + 1) begin
                    m_state[i] = pressed_now;
                    if (pressed_now) m_press[i] = 1'b1;
                    else             m_rel[i]   = 1'b1;
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        pipe1 = pipe0;
        pipe0 = kn;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("key_state", 32'(key_state), 32'(m_state));
        check("press_pulse", 32'(press_pulse), 32'(m_press));
        check("release_pulse", 32'(release_pulse), 32'(m_rel));
        check("key_any", 32'(key_any), 32'(|m_state));
    endtask

    // Drive at the falling edge, let one rising edge happen, compare at the next falling edge.
    task automatic cycle(input logic [NK-1:0] kn);
        key_n = kn;
        @(posedge clk);
        if (rst_n) model_edge(kn);
        else       model_reset();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic settle();
        for (int t = 0; t < 2 * D; t++) cycle('1);
    endtask

    initial begin
        int pe, re, npress, nrel;
        logic [NK-1:0] hold_val;
        int            hold_cnt [NK];

        rst_n = 1'b0;
        key_n = '1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_key_state", 32'(key_state), 32'h0);
        check("reset_press", 32'(press_pulse), 32'h0);
        check("reset_release", 32'(release_pulse), 32'h0);
        check("reset_key_any", 32'(key_any), 32'h0);
        rst_n = 1'b1;
        settle();

        // Clean press on key 0: pulse after edge D+2.
        pe = -1;
        for (int t = 0; t < D + 6; t++) begin
            cycle(4'b1110);
            if (press_pulse[0]) pe = t;
        end
        check("clean_press_latency", 32'(pe), 32'(D + 2));
        check("clean_press_state", 32'(key_state[0]), 32'h1);

        // Release glitch of 3 cycles: no release pulse.
        nrel = 0;
        for (int t = 0; t < 3; t++) begin cycle(4'b1111); nrel += int'(release_pulse[0]); end
        for (int t = 0; t < D + 4; t++) begin cycle(4'b1110); nrel += int'(release_pulse[0]); end
        check("release_glitch_pulses", 32'(nrel), 32'h0);

        // Clean release of key 0.
        re = -1;
        for (int t = 0; t < D + 6; t++) begin
            cycle(4'b1111);
            if (release_pulse[0]) re = t;
        end
        check("clean_release_latency", 32'(re), 32'(D + 2));
        check("clean_release_state", 32'(key_state[0]), 32'h0);
        settle();

        // Bounce on key 1: low 5, high 1, then held low.
        npress = 0; pe = -1;
        for (int t = 0; t < 5; t++) begin cycle(4'b1101); npress += int'(press_pulse[1]); end
        cycle(4'b1111); npress += int'(press_pulse[1]);
        for (int t = 0; t < D + 6; t++) begin
            cycle(4'b1101);
            npress += int'(press_pulse[1]);
            if (press_pulse[1]) pe = t;
        end
        check("bounce_press_count", 32'(npress), 32'h1);
        check("bounce_press_latency", 32'(pe), 32'(D + 2));
        settle();
        settle();

        // Short glitch on key 2: six cycles low is not enough.
        npress = 0;
        for (int t = 0; t < 6; t++) begin cycle(4'b1011); npress += int'(press_pulse[2]); end
        for (int t = 0; t < D + 4; t++) begin cycle(4'b1111); npress += int'(press_pulse[2]); end
        check("glitch_press_count", 32'(npress), 32'h0);
        check("glitch_key_state", 32'(key_state[2]), 32'h0);

        // All keys pressed together.
        pe = -1;
        for (int t = 0; t < D + 6; t++) begin
            cycle(4'b0000);
            if (press_pulse == 4'b1111) pe = t;
        end
        check("simultaneous_latency", 32'(pe), 32'(D + 2));
        settle();
        settle();

        // Reset in the middle of a press filter (counter at 5 after edge 7).
        for (int t = 0; t < 8; t++) cycle(4'b0111);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        npress = 0;
        for (int t = 0; t < 2; t++) begin cycle(4'b0111); npress += int'(press_pulse[3]); end
        check("reset_abort_pulses", 32'(npress), 32'h0);
        rst_n = 1'b1;
        pe = -1;
        for (int t = 0; t < D + 6; t++) begin
            cycle(4'b0111);
            if (press_pulse[3]) pe = t;
        end
        check("reset_requalify_latency", 32'(pe), 32'(D + 2));
        settle();
        settle();

        // Randomized bouncing: each key holds a random level for a random span.
        hold_val = '1;
        for (int i = 0; i < NK; i++) hold_cnt[i] = 0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < NK; i++) begin
                if (hold_cnt[i] == 0) begin
                    hold_val[i] = 1'($urandom_range(0, 1));
                    hold_cnt[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(D + 2, 3 * D))
                                                              : int'($urandom_range(1, D + 2));
                end
                hold_cnt[i]--;
            end
            cycle(hold_val);
            check("pulse_exclusive", 32'(press_pulse & release_pulse), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent push-button channels, 1..8.
REQ-002 Parameter DEBOUNCE_CYC, default 1000000: stable-level qualification time in clk cycles, legal range 2..2^20-1.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_n  input  N_KEYS  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-006 key_state  output  N_KEYS  debounced level per channel, 1 = pressed.
REQ-007 press_pulse  output  N_KEYS  one-cycle strobe per channel on qualified press.
REQ-008 release_pulse  output  N_KEYS  one-cycle strobe per channel on qualified release.
REQ-009 key_any  output  1  OR-reduction of key_state.

Function
REQ-010 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic; the synchronized value is sync.
REQ-011 Each channel SHALL own one FSM with states IDLE, PRESS_FILT, DOWN, REL_FILT and one counter of width clog2(DEBOUNCE_CYC).
REQ-012 IDLE: sync=0 -> PRESS_FILT with cnt cleared to 0; otherwise remain.
REQ-013 PRESS_FILT: sync=1 -> IDLE (bounce rejected, no pulse); sync=0 and cnt=DEBOUNCE_CYC-1 -> DOWN and press_pulse asserted; otherwise cnt increments.
REQ-014 DOWN: sync=1 -> REL_FILT with cnt cleared to 0; otherwise remain.
REQ-015 REL_FILT: sync=0 -> DOWN (bounce rejected, no pulse); sync=1 and cnt=DEBOUNCE_CYC-1 -> IDLE and release_pulse asserted; otherwise cnt increments.
REQ-016 The counter SHALL never wrap; it only counts inside a filter state and is cleared on entry to a filter state.
REQ-017 key_state SHALL be 1 in DOWN and REL_FILT and 0 in IDLE and PRESS_FILT, registered.
REQ-018 press_pulse and release_pulse SHALL be registered, high for exactly one cycle per qualified transition, and never high in the same cycle for the same channel.
REQ-019 Latency: with key_n stable low from the edge that first samples it (edge 0), press_pulse and key_state SHALL go high after edge DEBOUNCE_CYC+2; release is symmetric.
REQ-020 Channels SHALL be fully independent; simultaneous presses on several channels produce pulses in the same cycle.
REQ-021 key_any SHALL be a combinational OR of the key_state register.

Reset
REQ-022 On rst_n low, all synchronizer flops SHALL load 1 (released), all FSMs IDLE, all counters 0, all outputs 0.
REQ-023 Reset asserted mid-filter or mid-DOWN SHALL abort without emitting any pulse; after release a still-held key requalifies from IDLE with full latency.

Structure
REQ-024 FSM state encoding and the DEBOUNCE_CYC default SHALL live in shared package key_pkg.
REQ-025 One sub-module, key_filter_ch (synchronizer, FSM, counter for one key), SHALL be instantiated N_KEYS times in a generate loop; key_filter holds only instances and key_any.

Verification (DEBOUNCE_CYC=8, N_KEYS=4)
REQ-026 Clean press: key_n[0] 1->0 and held -> press_pulse[0] high for 1 cycle after edge 10, key_state[0]=1 from then, key_any=1.
REQ-027 Bounce: key_n[1] low 5 cycles, high 1 cycle, low held -> no pulse at the glitch; single press_pulse[1] after edge 10 counted from the final fall.
REQ-028 Short glitch: key_n[2] low for 6 cycles then high -> no press_pulse, key_state[2] stays 0.
REQ-029 Release: held key_n[0] returns high -> release_pulse[0] 1 cycle after edge 10 of the rise, key_state[0]=0; release glitch of 3 cycles yields no pulse.
REQ-030 Simultaneous: key_n=4'b0000 at once -> press_pulse=4'b1111 in the same cycle.
REQ-031 Reset mid-operation: rst_n low for 2 cycles during PRESS_FILT with cnt=5 -> outputs 0 immediately, no pulse; key held -> press_pulse 10 edges after rst_n release plus synchronizer refill.
